unidad_control_multiciclo: RTL and testbench
============================================

# unidad_control_multiciclo

Multicycle main control FSM for the 32-bit datapath. It sits directly upstream of the register bank and drives its `RegWrite` strobe and the write-register/write-data select lines. It also steers the ALU, PC and memory handshakes from the instruction opcode. The memory interface is handshaked, so fetch and data accesses may take any number of cycles.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Op  in  6  opcode field, from the instruction register (bits 31:26)
- MemListo  in  1  memory ready: the current read or write completes this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write request
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load qualified by ALU Zero
- PCSrc  out  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  out  2  00 = add, 01 = subtract, 10 = decode from funct
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- RegWrite  out  1  register bank write enable
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemtoReg  out  1  write data select: 0 = ALUOut, 1 = MDR
- Excepcion  out  1  illegal-opcode pulse, one cycle
- Estado  out  4  current state, for debug

## Operation
- Moore FSM with a 4-bit state register. The only Mealy terms are `IRWrite` and `PCWrite` in FETCH, which are gated by `MemListo`.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILEGAL=12. Codes 13-15 go to FETCH.
- Every output not listed for a state is 0.

States, asserted outputs and next state:
- FETCH: ALUSrcB=01; IRWrite=PCWrite=MemListo. Stays in FETCH until MemListo=1, then goes to DECODE.
- DECODE: ALUSrcB=11. Next state by Op:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → ILEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10. Op=100011 → MEMRD; otherwise → MEMWR.
- MEMRD: IorD=1. Stays until MemListo=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR: IorD=1, MemWrite=1, held high until MemListo=1. Next: FETCH.
- EXECUTE: ALUSrcA=1, ALUOp=10. Next: ALUWB.
- ALUWB: RegWrite=1, RegDst=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next: ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- ILEGAL: Excepcion=1. Next: FETCH. No register, memory or PC write occurs for the illegal instruction.

## Timing
Reset:
- `rst` high forces the state to FETCH immediately, with no clock edge needed.
- While `rst`=1, every write enable (IRWrite, PCWrite, MemWrite, RegWrite, Branch) is forced to 0.
- Other outputs during reset take their FETCH values: ALUSrcB=01, everything else 0, Estado=0.
- Reset asserted mid-MEMWR drops MemWrite in the same cycle. No partial write is held.

Clocking and sampling:
- State advances on the rising edge of `clk`.
- `Op` is sampled only in DECODE and MEMADR. It must be stable from the IRWrite edge onward.

Latency in cycles, with MemListo=1 on every first memory cycle:
- R-type: 4
- lw: 5
- sw: 4
- beq: 3
- addi: 4
- j: 3
- illegal: 3

Handshake:
- Each cycle of MemListo=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Outputs stay constant throughout a wait.
- MemListo is ignored in every other state.

Register bank strobe:
- RegWrite is high for exactly one cycle per lw, R-type or addi.
- RegWrite is never high for sw, beq, j or illegal opcodes.

## Configuration
- `CTRL_ADDI_EN`, when defined: opcode 001000 follows DECODE→ADDIEX→ADDIWB.
- When not defined: states ADDIEX and ADDIWB are not built, opcode 001000 goes to ILEGAL, and encodings 9-10 go to FETCH.

## Test plan
- Reset: assert rst in MEMWR with MemListo=0 → MemWrite=0 and Estado=0 immediately; after release, Estado=0.
- lw: Op=100011, MemListo=1 throughout → Estado sequence 0,1,2,3,4; RegWrite=1 only in state 4 with MemtoReg=1 and RegDst=0; 5 cycles total.
- Memory stall: Op=101011 with MemListo low for 3 cycles in MEMWR → MemWrite held high for 4 cycles, then Estado=0; RegWrite never 1.
- R-type: Op=000000 → RegWrite pulse with RegDst=1 in cycle 4. beq: Op=000100 → Branch=1, ALUOp=01, PCSrc=01 in cycle 3.
- Illegal opcode: Op=111111 → Excepcion high for one cycle in state 12, then FETCH; no write enables asserted.
- addi, with `CTRL_ADDI_EN` defined and undefined: Op=001000 → defined: RegWrite in cycle 4 with RegDst=0; undefined: Excepcion=1 in cycle 3.

Source files
------------

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle main control FSM for the 32-bit datapath.
// Drives register-bank write strobes, ALU/PC steering and the memory handshake.
// Optional feature macro: CTRL_ADDI_EN builds the addi path (ADDIEX/ADDIWB);
// without it, opcode 001000 is treated as illegal.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  FETCH   | instruction read, PC+4; waits for MemListo
//  DECODE  | register read, branch target precompute
//  MEMADR  | effective address for lw/sw
//  MEMRD   | data read; waits for MemListo
//  MEMWB   | load result to rt
//  MEMWR   | data write; waits for MemListo
//  EXECUTE | R-type ALU operation
//  ALUWB   | R-type result to rd
//  BRANCH  | beq compare and conditional PC load
//  ADDIEX  | addi ALU operation (CTRL_ADDI_EN only)
//  ADDIWB  | addi result to rt (CTRL_ADDI_EN only)
//  JUMP    | jump target to PC
//  ILEGAL  | illegal opcode exception pulse
module unidad_control_multiciclo (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       MemListo,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       Excepcion,
    output logic [3:0] Estado
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ILEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    // Output bundle order:
    // {iord, memwrite, pcwrite_u, branch, pcsrc[1:0], aluop[1:0], alusrca,
    //  alusrcb[1:0], regwrite, regdst, memtoreg, excepcion, en_fetch}
    // en_fetch enables the MemListo-gated IRWrite/PCWrite terms of FETCH.
    localparam logic [15:0] OUT_FETCH = 16'b0_0_0_0_00_00_0_01_0_0_0_0_1;

    state_t      estado;
    state_t      estado_sig;
    logic [15:0] salidas_q;

    function automatic logic [15:0] decodifica(input state_t s);
        logic [15:0] v;
        v = 16'b0;
        case (s)
            FETCH:   v = OUT_FETCH;
            DECODE:  v = 16'b0_0_0_0_00_00_0_11_0_0_0_0_0;
            MEMADR:  v = 16'b0_0_0_0_00_00_1_10_0_0_0_0_0;
            MEMRD:   v = 16'b1_0_0_0_00_00_0_00_0_0_0_0_0;
            MEMWB:   v = 16'b0_0_0_0_00_00_0_00_1_0_1_0_0;
            MEMWR:   v = 16'b1_1_0_0_00_00_0_00_0_0_0_0_0;
            EXECUTE: v = 16'b0_0_0_0_00_10_1_00_0_0_0_0_0;
            ALUWB:   v = 16'b0_0_0_0_00_00_0_00_1_1_0_0_0;
            BRANCH:  v = 16'b0_0_0_1_01_01_1_00_0_0_0_0_0;
`ifdef CTRL_ADDI_EN
            ADDIEX:  v = 16'b0_0_0_0_00_00_1_10_0_0_0_0_0;
            ADDIWB:  v = 16'b0_0_0_0_00_00_0_00_1_0_0_0_0;
`endif
            JUMP:    v = 16'b0_0_1_0_10_00_0_00_0_0_0_0_0;
            ILEGAL:  v = 16'b0_0_0_0_00_00_0_00_0_0_0_1_0;
            default: v = OUT_FETCH;
        endcase
        return v;
    endfunction

    // Next-state selection; Op only matters in DECODE and MEMADR.
    always_comb begin
        estado_sig = FETCH;
        case (estado)
            FETCH:   estado_sig = MemListo ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_RTYPE:     estado_sig = EXECUTE;
                    OP_LW, OP_SW: estado_sig = MEMADR;
                    OP_BEQ:       estado_sig = BRANCH;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      estado_sig = ADDIEX;
`endif
                    OP_J:         estado_sig = JUMP;
                    default:      estado_sig = ILEGAL;
                endcase
            end
            MEMADR:  estado_sig = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   estado_sig = MemListo ? MEMWB : MEMRD;
            MEMWB:   estado_sig = FETCH;
            MEMWR:   estado_sig = MemListo ? FETCH : MEMWR;
            EXECUTE: estado_sig = ALUWB;
            ALUWB:   estado_sig = FETCH;
            BRANCH:  estado_sig = FETCH;
`ifdef CTRL_ADDI_EN
            ADDIEX:  estado_sig = ADDIWB;
            ADDIWB:  estado_sig = FETCH;
`endif
            JUMP:    estado_sig = FETCH;
            ILEGAL:  estado_sig = FETCH;
            default: estado_sig = FETCH;
        endcase
    end

    // State register with outputs registered from the decoded next state,
    // so every Moore output changes exactly on the state edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= FETCH;
            salidas_q <= OUT_FETCH;
        end else begin
            estado    <= estado_sig;
            salidas_q <= decodifica(estado_sig);
        end
    end

    logic en_fetch;
    logic pcwrite_u;

    assign IorD      = salidas_q[15];
    assign MemWrite  = salidas_q[14];
    assign pcwrite_u = salidas_q[13];
    assign Branch    = salidas_q[12];
    assign PCSrc     = salidas_q[11:10];
    assign ALUOp     = salidas_q[9:8];
    assign ALUSrcA   = salidas_q[7];
    assign ALUSrcB   = salidas_q[6:5];
    assign RegWrite  = salidas_q[4];
    assign RegDst    = salidas_q[3];
    assign MemtoReg  = salidas_q[2];
    assign Excepcion = salidas_q[1];
    assign en_fetch  = salidas_q[0];
    assign Estado    = estado;

    // The fetch loads happen only in the cycle memory delivers the instruction;
    // rst gating keeps them low even while the reset value selects FETCH.
    assign IRWrite = en_fetch & MemListo & ~rst;
    assign PCWrite = pcwrite_u | (en_fetch & MemListo & ~rst);

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for unidad_control_multiciclo: directed opcode sequences, expected
// per-cycle outputs queued by the driver and checked by an independent monitor.
module tb_unidad_control_multiciclo;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic       MemListo;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0] PCSrc, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, MemtoReg, Excepcion;
    logic [3:0] Estado;

    unidad_control_multiciclo dut (
        .clk(clk), .rst(rst), .Op(Op), .MemListo(MemListo),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCSrc(PCSrc), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .Excepcion(Excepcion), .Estado(Estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] vec;
        int          id;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_id = 0;

    // Vector: {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUOp, ALUSrcA,
    //          ALUSrcB, RegWrite, RegDst, MemtoReg, Excepcion, Estado}
    function automatic logic [19:0] esperado(input int st, input logic ml, input logic r);
        logic       iord, memw, irw, pcw, br, asa, rw, rd, m2r, ex;
        logic [1:0] pcs, aop, asb;
        logic [3:0] e;
        iord = 0; memw = 0; irw = 0; pcw = 0; br = 0; asa = 0;
        rw = 0; rd = 0; m2r = 0; ex = 0; pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        e = 4'(st);
        if (r) begin
            asb = 2'b01;
            e = 4'd0;
        end else begin
            case (st)
                0:  begin asb = 2'b01; irw = ml; pcw = ml; end
                1:  asb = 2'b11;
                2:  begin asa = 1; asb = 2'b10; end
                3:  iord = 1;
                4:  begin rw = 1; m2r = 1; end
                5:  begin iord = 1; memw = 1; end
                6:  begin asa = 1; aop = 2'b10; end
                7:  begin rw = 1; rd = 1; end
                8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
                9:  begin asa = 1; asb = 2'b10; end
                10: rw = 1;
                11: begin pcs = 2'b10; pcw = 1; end
                12: ex = 1;
                default: ;
            endcase
        end
        return {iord, memw, irw, pcw, br, pcs, aop, asa, asb, rw, rd, m2r, ex, e};
    endfunction

    // One cycle of stimulus: drive inputs just after the edge, queue what the
    // DUT must show for the rest of that cycle.
    task automatic paso(input logic [5:0] op, input logic ml, input logic r, input int st);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r;
        Op = op;
        MemListo = ml;
        step_id++;
        x.vec = esperado(st, ml, r);
        x.id = step_id;
        q.push_back(x);
    endtask

    // Monitor: compare the DUT outputs mid-cycle against the oldest queued entry.
    always @(negedge clk) begin
        exp_t x;
        logic [19:0] act;
        if (q.size() > 0) begin
            x = q.pop_front();
            act = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUOp, ALUSrcA,
                   ALUSrcB, RegWrite, RegDst, MemtoReg, Excepcion, Estado};
            checks++;
            if (act !== x.vec) begin
                errors++;
                $display("FAIL cycle_%0d: got %b, expected %b", x.id, act, x.vec);
            end
        end
    end

    initial begin
        int espera;
        rst = 1'b1;
        Op = 6'b000000;
        MemListo = 1'b1;

        // Reset held: FETCH outputs with write enables suppressed even with MemListo=1.
        paso(6'b000000, 1'b1, 1'b1, 0);
        paso(6'b000000, 1'b1, 1'b1, 0);

        // lw, no stalls: 0,1,2,3,4.
        paso(6'b100011, 1'b1, 1'b0, 0);
        paso(6'b100011, 1'b1, 1'b0, 1);
        paso(6'b100011, 1'b1, 1'b0, 2);
        paso(6'b100011, 1'b1, 1'b0, 3);
        paso(6'b100011, 1'b1, 1'b0, 4);

        // lw with fetch and read stalls; MemListo=0 in non-memory states is ignored.
        paso(6'b100011, 1'b0, 1'b0, 0);
        paso(6'b100011, 1'b1, 1'b0, 0);
        paso(6'b100011, 1'b0, 1'b0, 1);
        paso(6'b100011, 1'b0, 1'b0, 2);
        paso(6'b100011, 1'b0, 1'b0, 3);
        paso(6'b100011, 1'b1, 1'b0, 3);
        paso(6'b100011, 1'b0, 1'b0, 4);

        // sw with 3 stall cycles in MEMWR, then back to FETCH.
        paso(6'b101011, 1'b1, 1'b0, 0);
        paso(6'b101011, 1'b1, 1'b0, 1);
        paso(6'b101011, 1'b1, 1'b0, 2);
        paso(6'b101011, 1'b0, 1'b0, 5);
        paso(6'b101011, 1'b0, 1'b0, 5);
        paso(6'b101011, 1'b0, 1'b0, 5);
        paso(6'b101011, 1'b1, 1'b0, 5);

        // R-type: 0,1,6,7.
        paso(6'b000000, 1'b1, 1'b0, 0);
        paso(6'b000000, 1'b1, 1'b0, 1);
        paso(6'b000000, 1'b0, 1'b0, 6);
        paso(6'b000000, 1'b1, 1'b0, 7);

        // beq: 0,1,8.
        paso(6'b000100, 1'b1, 1'b0, 0);
        paso(6'b000100, 1'b1, 1'b0, 1);
        paso(6'b000100, 1'b1, 1'b0, 8);

        // j: 0,1,11.
        paso(6'b000010, 1'b1, 1'b0, 0);
        paso(6'b000010, 1'b1, 1'b0, 1);
        paso(6'b000010, 1'b1, 1'b0, 11);

        // Illegal opcodes: 0,1,12.
        paso(6'b111111, 1'b1, 1'b0, 0);
        paso(6'b111111, 1'b1, 1'b0, 1);
        paso(6'b111111, 1'b1, 1'b0, 12);
        paso(6'b100000, 1'b1, 1'b0, 0);
        paso(6'b100000, 1'b1, 1'b0, 1);
        paso(6'b100000, 1'b1, 1'b0, 12);

        // addi: 0,1,9,10 when built, otherwise illegal.
        paso(6'b001000, 1'b1, 1'b0, 0);
        paso(6'b001000, 1'b1, 1'b0, 1);
`ifdef CTRL_ADDI_EN
        paso(6'b001000, 1'b1, 1'b0, 9);
        paso(6'b001000, 1'b1, 1'b0, 10);
`else
        paso(6'b001000, 1'b1, 1'b0, 12);
`endif

        // Reset asserted mid-MEMWR with MemListo=0: MemWrite drops, Estado=0 at once.
        paso(6'b101011, 1'b1, 1'b0, 0);
        paso(6'b101011, 1'b1, 1'b0, 1);
        paso(6'b101011, 1'b1, 1'b0, 2);
        paso(6'b101011, 1'b0, 1'b0, 5);
        paso(6'b101011, 1'b0, 1'b1, 0);
        paso(6'b101011, 1'b0, 1'b1, 0);
        // Release: FETCH, then a full R-type confirms normal operation.
        paso(6'b000000, 1'b0, 1'b0, 0);
        paso(6'b000000, 1'b1, 1'b0, 0);
        paso(6'b000000, 1'b1, 1'b0, 1);
        paso(6'b000000, 1'b1, 1'b0, 6);
        paso(6'b000000, 1'b1, 1'b0, 7);
        paso(6'b000000, 1'b0, 1'b0, 0);

        espera = 0;
        while (q.size() > 0 && espera < 20) begin
            @(posedge clk);
            espera++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
